// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and fetches over a variable-latency req/ack
// handshake. It handles EXE redirects and hazard freeze. Outputs are zero whenever
// no instruction is presented.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_addr,
  if_fetch_stage_if.master         imem_io,
  output logic [31:0]              PC,
  output logic [31:0]              Instruction,
  output logic                     inst_valid
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] pc_next_seq;

  // Sequential successor; wraps naturally modulo 2^32.
  assign pc_next_seq = pc_q + 32'(PC_INC);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      hold_inst_q   <= '0;
      hold_pc_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    hold_inst_d       = hold_inst_q;
    hold_pc_d         = hold_pc_q;
    redirect_pc_d     = redirect_pc_q;
    imem_io.imem_req  = 1'b0;
    imem_io.imem_addr = pc_q;
    inst_valid        = 1'b0;
    PC                = '0;
    Instruction       = '0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (branch_taken) pc_d = branch_addr;
      end

      StReq: begin
        imem_io.imem_req = 1'b1;
        if (!imem_io.imem_ack) begin
          // Address must stay stable until ack, so a redirect waits in DRAIN.
          if (branch_taken) begin
            redirect_pc_d = branch_addr;
            state_d       = StDrain;
          end
        end else if (branch_taken) begin
          pc_d = branch_addr;
        end else begin
          inst_valid  = 1'b1;
          Instruction = imem_io.imem_rdata;
          PC          = pc_next_seq;
          if (freeze) begin
            // IF/ID ignores this cycle; keep the pair until freeze lifts.
            hold_inst_d = imem_io.imem_rdata;
            hold_pc_d   = pc_next_seq;
            state_d     = StHold;
          end else begin
            pc_d = pc_next_seq;
          end
        end
      end

      StHold: begin
        inst_valid  = 1'b1;
        Instruction = hold_inst_q;
        PC          = hold_pc_q;
        if (branch_taken) begin
          pc_d    = branch_addr;
          state_d = StReq;
        end else if (!freeze) begin
          pc_d    = pc_next_seq;
          state_d = StReq;
        end
      end

      StDrain: begin
        imem_io.imem_req = 1'b1;
        if (branch_taken) redirect_pc_d = branch_addr;
        if (imem_io.imem_ack) begin
          // Last redirect wins, including one arriving with the ack.
          pc_d    = branch_taken ? branch_addr : redirect_pc_q;
          state_d = StReq;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the ARM pipeline. Owns the program counter and issues requests to instruction memory over a req/ack handshake with variable latency. Handles branch redirects from EXE and freeze from hazard detection. Drives the PC+4 / instruction pair into the IF/ID pipeline register. When no instruction is available it drives an all-zero bubble, the same encoding as an IF/ID flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, byte increment between sequential fetches

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  reset; one clock, synchronous, active-low (rst==0 at a rising clk edge resets)
freeze  input  1  hazard stall; hold current instruction, do not advance PC
branch_taken  input  1  EXE-stage redirect; priority over freeze
branch_addr  input  32  redirect target
imem_req  output  1  fetch request
imem_addr  output  32  fetch address; stable while imem_req=1 until ack
imem_rdata  input  32  instruction word; valid only in the cycle imem_ack=1
imem_ack  input  1  one-cycle completion pulse; latency >=1 cycle after req
PC  output  32  fetched address + PC_INC; 0 when inst_valid=0
Instruction  output  32  fetched word; 0 when inst_valid=0
inst_valid  output  1  PC/Instruction carry a real instruction this cycle

Behaviour:
- Registers: pc_reg, state, hold_inst, hold_pc, redirect_pc.
- States: IDLE, REQ, HOLD, DRAIN.
- Reset (rst=0 at edge):
  - pc_reg=RESET_PC, state=IDLE, hold regs=0.
  - Outputs are decoded from state, so one cycle after reset: imem_req=0, inst_valid=0, PC=0, Instruction=0.
  - Reset mid-transaction abandons the outstanding request. imem_req drops the cycle after reset, and a late ack is ignored because state is IDLE.
- IDLE:
  - No request.
  - Next state REQ.
  - If branch_taken, pc_reg<=branch_addr.
- REQ:
  - imem_req=1, imem_addr=pc_reg.
  - ack=0, branch_taken=1: redirect_pc<=branch_addr; ->DRAIN. The address must stay stable, so there is no early abort.
  - ack=0, branch_taken=0: stay. freeze is irrelevant.
  - ack=1, branch_taken=1: discard imem_rdata; pc_reg<=branch_addr; stay REQ. The new address appears next cycle. inst_valid=0.
  - ack=1, freeze=1, branch_taken=0:
    - Outputs are valid this cycle (inst_valid=1, Instruction=imem_rdata, PC=pc_reg+PC_INC). The IF/ID register ignores them because freeze is high.
    - Capture hold_inst<=imem_rdata, hold_pc<=pc_reg+PC_INC; ->HOLD. pc_reg is unchanged.
  - ack=1, freeze=0, branch_taken=0: combinational pass-through: inst_valid=1, Instruction=imem_rdata, PC=pc_reg+PC_INC. pc_reg<=pc_reg+PC_INC; stay REQ.
  - Back-to-back acks therefore give one instruction per cycle.
- HOLD:
  - imem_req=0; inst_valid=1, Instruction=hold_inst, PC=hold_pc.
  - branch_taken=1: pc_reg<=branch_addr; ->REQ. The held instruction is dropped.
  - freeze=1: stay.
  - freeze=0: pc_reg<=pc_reg+PC_INC; ->REQ. IF/ID captures the held pair at this edge.
- DRAIN:
  - imem_req=1, imem_addr=pc_reg (the stale address); inst_valid=0.
  - On ack: discard data; pc_reg<=redirect_pc; ->REQ.
  - A further branch_taken in DRAIN overwrites redirect_pc (last redirect wins).
- Priority: reset > branch_taken > freeze > normal advance.
- Arithmetic: PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment check; branch_addr is used as given.
- Invariant: imem_addr never changes while imem_req=1 and no ack has been seen.
- Invariant: inst_valid=0 forces PC=0 and Instruction=0.

Test Plan:
- Reset, 1-cycle-latency memory returning addr as data, freeze=0, branch=0. Required:
  - imem_addr sequence 0,4,8,C.
  - PC outputs 4,8,C,10; Instruction 0,4,8,C; inst_valid=1 each ack cycle.
- Hold rst=0 for 3 cycles with ack asserted. Required: imem_req=0, inst_valid=0, PC=0, Instruction=0 throughout.
  - After release, first request addr=RESET_PC.
- Freeze for 3 cycles on ack of addr 8 (data 32'hE3A0_1005). Required:
  - inst_valid=1, Instruction=E3A01005, PC=C held for all 3 cycles; no imem_req.
  - After release, next request addr=C.
- branch_taken=1, branch_addr=0x100 in the ack cycle of addr 4. Required:
  - inst_valid=0 that cycle; next imem_addr=0x100.
  - First valid output PC=0x104.
- Branch to 0x200 while a 4-cycle-latency request to addr 8 is pending. Required:
  - imem_addr stays 8 until ack; ack data discarded (inst_valid=0).
  - Next imem_addr=0x200.
  - A second branch to 0x300 before the ack gives next imem_addr=0x300.
- branch_addr=32'hFFFF_FFFC, then sequential fetch. Required: next imem_addr=0, output PC=0 for the FFFF_FFFC fetch.
- Branch during HOLD with freeze still 1. Required: held instruction dropped, next request addr=branch_addr.
- Reset asserted mid-request, with ack arriving the cycle after reset. Required: the ack is ignored, and the sequence restarts at RESET_PC.
